// File: rtl/cbus_pkg.sv
// cbus_pkg: shared types and constants for the c_* config-bus initiator.
// State encoding, access size codes, address mask and default timeout.
package cbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [31:0] ADDR_WMASK = 32'hFFFF_FFFC;

  localparam int CB_TIMEOUT = 15;
  localparam int CB_TW      = 4;

endpackage

// File: rtl/cbus_master.sv
// cbus_master: single-outstanding initiator for the c_* config bus.
// Optional ready timeout enabled by defining CBUS_MASTER_TIMEOUT_EN.
module cbus_master
  import cbus_pkg::*;
#(
  parameter int TIMEOUT = CB_TIMEOUT,
  parameter int TW      = CB_TW
) (
  input  logic        c_clk,
  input  logic        c_rstb,
  input  logic        h_valid,
  output logic        h_ready,
  input  logic [31:0] h_addr,
  input  logic [31:0] h_wdata,
  input  logic        h_write,
  input  logic [1:0]  h_size,
  output logic        r_valid,
  output logic [31:0] r_rdata,
  output logic        r_err,
  output logic        c_valid,
  output logic [31:0] c_addr,
  output logic [31:0] c_wdata,
  output logic        c_write,
  output logic [1:0]  c_size,
  input  logic        c_ready,
  input  logic [31:0] c_rdata
);

  if ((TIMEOUT < 1) || (TIMEOUT > (2**TW) - 1)) begin : g_bad_tmo
    $error("cbus_master: TIMEOUT out of range for TW");
  end

  state_t state, state_nxt;
  logic   accept;
  logic   done;
  logic   resp;

`ifdef CBUS_MASTER_TIMEOUT_EN
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  logic [TW-1:0] cnt;
  logic          tmo;
`endif

  // Request is taken only in IDLE; held low while in reset.
  assign h_ready = c_rstb && (state == ST_IDLE);
  assign c_valid = (state == ST_BUS);

  // State register.
  always_ff @(posedge c_clk or negedge c_rstb) begin
    if (!c_rstb) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state and per-edge event strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
`ifdef CBUS_MASTER_TIMEOUT_EN
    tmo       = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (h_valid) begin
          accept    = 1'b1;
          state_nxt = ST_BUS;
        end
      end
      ST_BUS: begin
        if (c_ready) begin
          done      = 1'b1;
          state_nxt = ST_GAP;
        end
`ifdef CBUS_MASTER_TIMEOUT_EN
        else if (cnt == TMAX) begin
          tmo       = 1'b1;
          state_nxt = ST_GAP;
        end
`endif
      end
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef CBUS_MASTER_TIMEOUT_EN
  assign resp = done | tmo;
`else
  assign resp = done;
`endif

  // Bus request fields, captured at acceptance and held through GAP.
  always_ff @(posedge c_clk or negedge c_rstb) begin
    if (!c_rstb) begin
      c_addr  <= '0;
      c_wdata <= '0;
      c_write <= 1'b0;
      c_size  <= '0;
    end else if (accept) begin
      c_addr  <= h_addr;
      c_wdata <= h_wdata;
      c_write <= h_write;
      c_size  <= h_size;
    end
  end

  // Response strobe and held read data.
  always_ff @(posedge c_clk or negedge c_rstb) begin
    if (!c_rstb) begin
      r_valid <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_valid <= resp;
      if (done)      r_rdata <= c_write ? '0 : c_rdata;
      else if (resp) r_rdata <= '0;
    end
  end

`ifdef CBUS_MASTER_TIMEOUT_EN
  // Cycles spent in BUS without ready; cleared on acceptance.
  always_ff @(posedge c_clk or negedge c_rstb) begin
    if (!c_rstb)                     cnt <= '0;
    else if (accept)                 cnt <= '0;
    else if (c_valid && !c_ready)    cnt <= cnt + 1'b1;
  end

  // Error flag, held until the next response.
  always_ff @(posedge c_clk or negedge c_rstb) begin
    if (!c_rstb)   r_err <= 1'b0;
    else if (resp) r_err <= tmo;
  end
`else
  assign r_err = 1'b0;
`endif

endmodule

// File: tb/tb_cbus_master.sv
// tb_cbus_master: directed plus random transactions against an irq-mask
// style responder; expectations come from a simple mask/latency model.
module tb_cbus_master;

  logic        c_clk = 1'b0;
  logic        c_rstb;
  logic        h_valid;
  logic        h_ready;
  logic [31:0] h_addr;
  logic [31:0] h_wdata;
  logic        h_write;
  logic [1:0]  h_size;
  logic        r_valid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        c_valid;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_write;
  logic [1:0]  c_size;
  logic        c_ready;
  logic [31:0] c_rdata;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // responder state
  logic [31:0] mask;
  logic        rdy_q;
  logic        dead = 1'b0;
  logic        spur = 1'b0;
  int          ntx  = 0;

  // reference model: last written mask word
  logic [31:0] mdl;

  cbus_master dut (
    .c_clk  (c_clk),
    .c_rstb (c_rstb),
    .h_valid(h_valid),
    .h_ready(h_ready),
    .h_addr (h_addr),
    .h_wdata(h_wdata),
    .h_write(h_write),
    .h_size (h_size),
    .r_valid(r_valid),
    .r_rdata(r_rdata),
    .r_err  (r_err),
    .c_valid(c_valid),
    .c_addr (c_addr),
    .c_wdata(c_wdata),
    .c_write(c_write),
    .c_size (c_size),
    .c_ready(c_ready),
    .c_rdata(c_rdata)
  );

  always #5 c_clk = ~c_clk;

  // irq-mask responder: registered ready, lane-shifted read data
  always_ff @(posedge c_clk or negedge c_rstb) begin
    if (!c_rstb) begin
      rdy_q <= 1'b0;
      mask  <= '0;
    end else begin
      rdy_q <= c_valid && !dead;
      if (c_valid && c_ready && c_write) mask <= c_wdata;
    end
  end

  assign c_ready = rdy_q | spur;
  assign c_rdata = mask >> (8 * c_addr[1:0]);

  always @(posedge c_clk) if (c_valid && c_ready) ntx++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return mdl >> (8 * a[1:0]);
  endfunction

  // One request with full latency checks; starts and ends in IDLE.
  task automatic txn(input logic [31:0] a, input logic [31:0] wd,
                     input logic w, input logic [1:0] sz);
    logic [31:0] exp;
    exp = w ? 32'h0 : model_rd(a);
    @(negedge c_clk);
    chk("h_ready idle", {31'd0, h_ready}, 1);
    h_valid = 1'b1; h_addr = a; h_wdata = wd;
    h_write = w; h_size = sz;
    @(posedge c_clk);
    @(negedge c_clk);
    h_valid = 1'b0;
    chk("c_valid E0", {31'd0, c_valid}, 1);
    chk("c_addr E0", c_addr, a);
    chk("c_wdata E0", c_wdata, wd);
    chk("c_wr_sz E0", {29'd0, c_write, c_size}, {29'd0, w, sz});
    chk("h_ready busy", {31'd0, h_ready}, 0);
    @(negedge c_clk);
    chk("c_valid E1", {31'd0, c_valid}, 1);
    chk("r_valid E1", {31'd0, r_valid}, 0);
    @(negedge c_clk);
    chk("c_valid E2", {31'd0, c_valid}, 0);
    chk("r_valid E2", {31'd0, r_valid}, 1);
    chk("r_err E2", {31'd0, r_err}, 0);
    chk("r_rdata E2", r_rdata, exp);
    chk("c_addr gap", c_addr, a);
    @(negedge c_clk);
    chk("r_valid E3", {31'd0, r_valid}, 0);
    chk("h_ready E3", {31'd0, h_ready}, 1);
    chk("r_rdata hold", r_rdata, exp);
    if (w) mdl = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tx0;
    int cv_cnt;
    int rv_cnt;
    logic [31:0] a;
    logic [31:0] d;
    logic w;

    c_rstb = 1'b0; h_valid = 1'b0; h_addr = '0;
    h_wdata = '0; h_write = 1'b0; h_size = '0;
    mdl = '0;
    #12;
    chk("rst c_valid", {31'd0, c_valid}, 0);
    chk("rst r_valid", {31'd0, r_valid}, 0);
    chk("rst h_ready", {31'd0, h_ready}, 0);
    chk("rst r_rdata", r_rdata, 0);
    chk("rst c_addr", c_addr, 0);
    @(negedge c_clk);
    c_rstb = 1'b1;
    @(negedge c_clk);
    chk("post-rst h_ready", {31'd0, h_ready}, 1);

    // directed write then reads
    tx0 = ntx;
    txn(32'h0, 32'h0000_001F, 1'b1, 2'd2);
    chk("slave mask", mask, 32'h0000_001F);
    txn(32'h0, 32'h0, 1'b0, 2'd2);
    txn(32'h1, 32'h0, 1'b0, 2'd0);
    chk("tx count dir", ntx - tx0, 3);

    // back-to-back with h_valid held
    tx0 = ntx;
    @(negedge c_clk);
    h_valid = 1'b1; h_addr = 32'h0; h_write = 1'b0; h_size = 2'd2;
    chk("b2b hr0", {31'd0, h_ready}, 1);
    for (int i = 1; i <= 8; i++) begin
      @(posedge c_clk);
      @(negedge c_clk);
      if (i == 5) h_valid = 1'b0;
      chk("b2b h_ready", {31'd0, h_ready}, (i % 4 == 0) ? 1 : 0);
      chk("b2b r_valid", {31'd0, r_valid}, (i % 4 == 3) ? 1 : 0);
    end
    chk("b2b tx count", ntx - tx0, 2);

    // spurious ready in IDLE
    @(negedge c_clk);
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge c_clk);
      chk("spur idle r_valid", {31'd0, r_valid}, 0);
      chk("spur idle h_ready", {31'd0, h_ready}, 1);
    end
    spur = 1'b0;

    // spurious ready extended through GAP
    @(negedge c_clk);
    h_valid = 1'b1; h_addr = 32'h2; h_write = 1'b0;
    @(negedge c_clk);
    h_valid = 1'b0;
    @(negedge c_clk);
    @(negedge c_clk);
    chk("gap r_valid", {31'd0, r_valid}, 1);
    chk("gap r_rdata", r_rdata, model_rd(32'h2));
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge c_clk);
      chk("spur gap r_valid", {31'd0, r_valid}, 0);
      chk("spur gap c_valid", {31'd0, c_valid}, 0);
      chk("spur gap h_ready", {31'd0, h_ready}, 1);
    end
    spur = 1'b0;

    // random traffic against the model
    for (int k = 0; k < 12; k++) begin
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      a = w ? 32'h0 : 32'($urandom_range(0, 3));
      txn(a, d, w, 2'd2);
    end

    // unresponsive slave
    dead = 1'b1;
    @(negedge c_clk);
    h_valid = 1'b1; h_addr = 32'h0; h_write = 1'b0;
    @(negedge c_clk);
    h_valid = 1'b0;
    cv_cnt = 1;
    rv_cnt = 0;
`ifdef CBUS_MASTER_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      @(negedge c_clk);
      if (!c_valid) break;
      cv_cnt++;
    end
    chk("tmo c_valid cycles", 32'(cv_cnt), 15);
    chk("tmo r_valid", {31'd0, r_valid}, 1);
    chk("tmo r_err", {31'd0, r_err}, 1);
    chk("tmo r_rdata", r_rdata, 0);
    @(negedge c_clk);
    chk("tmo r_valid drop", {31'd0, r_valid}, 0);
    chk("tmo h_ready", {31'd0, h_ready}, 1);
    chk("tmo r_err hold", {31'd0, r_err}, 1);
    h_valid = 1'b1;
    @(negedge c_clk);
    h_valid = 1'b0;
    @(negedge c_clk);
`else
    for (int i = 0; i < 110; i++) begin
      @(negedge c_clk);
      if (c_valid) cv_cnt++;
      if (r_valid) rv_cnt++;
    end
    chk("hang c_valid cycles", 32'(cv_cnt), 111);
    chk("hang r_valid", 32'(rv_cnt), 0);
`endif

    // reset in the middle of a BUS cycle
    chk("pre-rst c_valid", {31'd0, c_valid}, 1);
    c_rstb = 1'b0;
    #1;
    chk("arst c_valid", {31'd0, c_valid}, 0);
    chk("arst r_valid", {31'd0, r_valid}, 0);
    chk("arst h_ready", {31'd0, h_ready}, 0);
    chk("arst r_err", {31'd0, r_err}, 0);
    mdl = '0;
    dead = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge c_clk);
      if (r_valid) rv_cnt++;
    end
    c_rstb = 1'b1;
    @(negedge c_clk);
    if (r_valid) rv_cnt++;
    chk("arst no resp", 32'(rv_cnt), 0);
    chk("arst h_ready rel", {31'd0, h_ready}, 1);
    txn(32'h0, 32'h0, 1'b0, 2'd2);
    txn(32'h0, 32'hA5C3_0F12, 1'b1, 2'd2);
    txn(32'h3, 32'h0, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cbus_master.md
Name: cbus_master

Overview:
- Initiator for the c_* configuration bus (c_valid/c_ready, c_addr, c_wdata, c_write, c_size, c_rdata): the other end of the responder handshake used by the config slaves (irq mask, etc.).
- Accepts single read/write requests from a host port and runs one bus transaction at a time.
- Returns read data or an error.
- Sits between a CPU/debug bridge and the config-slave address space.

Parameters:
- TIMEOUT, 15, cycles waited for c_ready before aborting (1..2^TW-1).
- TW, 4, width of the timeout counter.

Ports:
- c_clk  in  1  clock
- c_rstb  in  1  async active-low reset
- h_valid  in  1  host request valid
- h_ready  out  1  host request accepted (high only in IDLE)
- h_addr  in  32  request byte address
- h_wdata  in  32  write data, passed unshifted (slave does lane shift)
- h_write  in  1  1=write, 0=read
- h_size  in  2  0=byte, 1=half, 2=word, 3=reserved (forwarded)
- r_valid  out  1  one-cycle response strobe
- r_rdata  out  32  read data captured from c_rdata (0 for writes/errors)
- r_err  out  1  timeout flag, qualified by r_valid
- c_valid  out  1  bus request
- c_addr  out  32  bus address
- c_wdata  out  32  bus write data
- c_write  out  1  bus write
- c_size  out  2  bus size
- c_ready  in  1  registered responder ready (asserted the cycle after it samples c_valid)
- c_rdata  in  32  responder read data, valid with c_ready

Behaviour:
- Reset: clock c_clk, reset c_rstb asynchronous active-low. All outputs go to 0, state=IDLE, counter=0.
- States:
  - IDLE: h_ready=1. On h_valid at an edge, capture addr/wdata/write/size into c_* registers and go to BUS; c_valid=1 from the next cycle.
  - BUS: c_valid held high; c_addr, c_wdata, c_write and c_size stable.
    - Edge with c_ready=1: capture r_rdata = write ? 0 : c_rdata, pulse r_valid=1 with r_err=0, drop c_valid, go to GAP.
  - GAP: exactly one cycle with c_valid=0. It absorbs the trailing c_ready, which the responder raises because it sampled c_valid at the completing edge. c_ready is ignored here. c_addr is still held so the slave's combinational rdata shift stays stable. Then return to IDLE.
- Latency for a responsive slave:
  - Acceptance edge E0.
  - c_valid high after E0.
  - c_ready high after E1.
  - r_valid high for one cycle after E2.
  - h_ready high again after E3.
  - Back-to-back throughput: one transaction per 4 cycles.
- h_ready is combinational from state (IDLE only). A request presented during BUS/GAP waits with no loss; the host must hold it.
- r_valid lasts exactly one cycle. r_rdata and r_err hold their values until the next response.
- A c_ready seen in IDLE or GAP (spurious) is ignored.
- Reset mid-transaction aborts immediately and gives no response. The slave must also be reset (shared c_rstb).

Optional Feature:
- Macro CBUS_MASTER_TIMEOUT_EN.
- Defined:
  - Counter clears on entering BUS and increments each BUS cycle without c_ready.
  - When the counter reaches TIMEOUT, at that edge: drop c_valid, r_valid=1, r_err=1, r_rdata=0, go to GAP.
  - If c_ready and the timeout coincide at the same edge, c_ready wins (normal completion, r_err=0).
- Undefined: no counter, BUS waits indefinitely, r_err tied to 0.

Decomposition:
- Package cbus_pkg holds:
  - state encoding (IDLE=0, BUS=1, GAP=2)
  - size codes (SZ_B=0, SZ_H=1, SZ_W=2)
  - address word-align mask 32'hFFFF_FFFC
  - default TIMEOUT/TW
- No sub-module: the timeout counter is inline under the macro. The bench pairs the DUT with the existing irq-mask responder as the slave.

Test Plan:
- Write h_addr=0, h_wdata=32'h0000_001F, h_write=1, h_size=2 to the irq responder -> c_valid is high for exactly 2 cycles, r_valid pulses 3 cycles after acceptance with r_err=0 and r_rdata=0; the slave mask then reads 0x1F.
- Read h_addr=0 after the write above -> r_rdata=32'h0000_001F; read h_addr=1 -> r_rdata=32'h0000_0000 (slave shift by 8), and c_addr stays stable through GAP.
- Two requests held back-to-back (h_valid constantly 1) -> h_ready pulses every 4th cycle, each request produces exactly one r_valid, and no duplicate bus transaction occurs from the trailing c_ready.
- With CBUS_MASTER_TIMEOUT_EN and TIMEOUT=15, slave c_ready tied 0 -> c_valid drops after 15 BUS cycles, r_valid=1, r_err=1, r_rdata=0, then IDLE; without the macro, c_valid stays high for 100+ cycles.
- Assert c_rstb low in the BUS cycle -> c_valid, r_valid, h_ready and r_err go to 0 asynchronously with no response pulse; after release h_ready=1 and a new read completes normally.
- Force c_ready=1 while in IDLE or GAP -> no r_valid and no state change.
